// File: rtl/controller_hub.sv
// controller_hub
//
// Polls NUM_CONTROLLERS serial shift-register game controllers in parallel
// and presents two CPU-readable registers per controller:
//   held    - button state captured by the most recent completed fetch
//   pressed - sticky record of buttons that went down since the last
//             pressed-read (cleared by a strobed read of that register)
// A fetch is launched by a one-cycle start_fetch pulse (typically once per
// frame). The controller shift clock is derived internally from cpu_clk.
//
// Ports
//   cpu_clk              sole clock, rising edge
//   rst                  asynchronous reset, active low
//   start_fetch          one-cycle fetch request (ignored while busy)
//   reg_select           CPU access to this block decoded this cycle
//   read_strobe          qualifies the access as a read (clear-on-read)
//   reg_address          bit0: 0=held, 1=pressed; upper bits: controller index
//   data_out             combinational read data, 0 when not selected or
//                        when the index is out of range
//   controller_clk       shift clock to controllers (idles high)
//   controller_latch     parallel-load strobe to controllers
//   controller_data_in_B serial data per controller, active low
//   busy                 fetch in progress
//   fetch_done           one-cycle pulse while new values are committed
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start_fetch; clk high, latch low
// S_LATCH  | latch high for one full bit period (2*CLK_DIV cycles)
// S_SHIFT  | NUM_BUTTONS bit periods: clk low CLK_DIV, high CLK_DIV;
//          | all channels sampled on the last cycle of each low phase
// S_COMMIT | one cycle: shift data moves into held/pressed, fetch_done high

module controller_hub #(
    parameter int NUM_CONTROLLERS = 4,
    parameter int NUM_BUTTONS     = 8,
    parameter int CLK_DIV         = 6
) (
    input  logic                              cpu_clk,
    input  logic                              rst,
    input  logic                              start_fetch,
    input  logic                              reg_select,
    input  logic                              read_strobe,
    input  logic [$clog2(NUM_CONTROLLERS):0]  reg_address,
    output logic [NUM_BUTTONS-1:0]            data_out,
    output logic                              controller_clk,
    output logic                              controller_latch,
    input  logic [NUM_CONTROLLERS-1:0]        controller_data_in_B,
    output logic                              busy,
    output logic                              fetch_done
);

    localparam int PERIOD = 2 * CLK_DIV;
    localparam int DW     = $clog2(PERIOD);
    localparam int BW     = $clog2(NUM_BUTTONS + 1);
    localparam int IW     = (NUM_CONTROLLERS > 1) ? $clog2(NUM_CONTROLLERS) : 1;

    localparam logic [DW-1:0] DIV_SAMPLE = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(PERIOD - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(NUM_BUTTONS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LATCH  = 2'd1,
        S_SHIFT  = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t                 state;
    logic [DW-1:0]          div_cnt;
    logic [BW-1:0]          bit_idx;
    logic [NUM_BUTTONS-1:0] shift_reg   [NUM_CONTROLLERS];
    logic [NUM_BUTTONS-1:0] held_reg    [NUM_CONTROLLERS];
    logic [NUM_BUTTONS-1:0] pressed_reg [NUM_CONTROLLERS];
    logic [NUM_BUTTONS-1:0] shift_in    [NUM_CONTROLLERS];
    logic [NUM_CONTROLLERS-1:0] clr_vec;
    logic [IW-1:0]          index;

    // Controller index from the upper address bits; a single-controller
    // build has no index bits and always addresses controller 0.
    generate
        if (NUM_CONTROLLERS > 1) begin : g_index
            assign index = reg_address[IW:1];
        end else begin : g_index_single
            assign index = 1'b0;
        end
    endgenerate

    // Next shift value per channel; the line is active low, so invert to
    // store 1 = button down. Written as shift-then-insert so that a
    // one-button build needs no special case.
    always_comb begin
        for (int c = 0; c < NUM_CONTROLLERS; c++) begin
            shift_in[c]    = shift_reg[c] << 1;
            shift_in[c][0] = ~controller_data_in_B[c];
        end
    end

    // Clear request for a strobed read of a valid pressed register. An
    // out-of-range index matches no channel and therefore clears nothing.
    always_comb begin
        clr_vec = '0;
        for (int c = 0; c < NUM_CONTROLLERS; c++) begin
            if (reg_select && read_strobe && reg_address[0] && (index == IW'(c)))
                clr_vec[c] = 1'b1;
        end
    end

    // Read mux; an index with no matching channel leaves data_out at 0.
    always_comb begin
        data_out = '0;
        for (int c = 0; c < NUM_CONTROLLERS; c++) begin
            if (reg_select && (index == IW'(c)))
                data_out = reg_address[0] ? pressed_reg[c] : held_reg[c];
        end
    end

    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            state            <= S_IDLE;
            div_cnt          <= '0;
            bit_idx          <= '0;
            controller_clk   <= 1'b1;
            controller_latch <= 1'b0;
            busy             <= 1'b0;
            fetch_done       <= 1'b0;
            for (int c = 0; c < NUM_CONTROLLERS; c++) begin
                shift_reg[c]   <= '0;
                held_reg[c]    <= '0;
                pressed_reg[c] <= '0;
            end
        end else begin
            fetch_done <= 1'b0;

            // Clear-on-read applies in any state; the COMMIT branch below
            // overrides this with the merged clear-plus-new-edges value.
            for (int c = 0; c < NUM_CONTROLLERS; c++) begin
                if (clr_vec[c])
                    pressed_reg[c] <= '0;
            end

            case (state)
                S_IDLE: begin
                    controller_clk   <= 1'b1;
                    controller_latch <= 1'b0;
                    if (start_fetch) begin
                        state            <= S_LATCH;
                        div_cnt          <= '0;
                        bit_idx          <= '0;
                        controller_latch <= 1'b1;
                        busy             <= 1'b1;
                    end
                end

                S_LATCH: begin
                    if (div_cnt == DIV_LAST) begin
                        state            <= S_SHIFT;
                        div_cnt          <= '0;
                        controller_latch <= 1'b0;
                        controller_clk   <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                S_SHIFT: begin
                    // Sample just before the rising edge, when the
                    // controllers have held the current bit for the whole
                    // low phase.
                    if (div_cnt == DIV_SAMPLE) begin
                        for (int c = 0; c < NUM_CONTROLLERS; c++)
                            shift_reg[c] <= shift_in[c];
                        controller_clk <= 1'b1;
                    end
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (bit_idx == BIT_LAST) begin
                            state      <= S_COMMIT;
                            fetch_done <= 1'b1;
                        end else begin
                            bit_idx        <= bit_idx + 1'b1;
                            controller_clk <= 1'b0;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                S_COMMIT: begin
                    // A read clearing this cycle removes only the older
                    // sticky bits; edges found by this fetch survive.
                    for (int c = 0; c < NUM_CONTROLLERS; c++) begin
                        held_reg[c]    <= shift_reg[c];
                        pressed_reg[c] <= (pressed_reg[c] & ~{NUM_BUTTONS{clr_vec[c]}})
                                        | (shift_reg[c] & ~held_reg[c]);
                    end
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controller_hub.sv
module tb_controller_hub;

    localparam int NC  = 3;
    localparam int NB  = 8;
    localparam int CD  = 6;
    localparam int AW  = $clog2(NC) + 1;
    localparam int LAT = (NB + 1) * 2 * CD + 1;

    logic          cpu_clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_fetch = 1'b0;
    logic          reg_select = 1'b0;
    logic          read_strobe = 1'b0;
    logic [AW-1:0] reg_address = '0;
    logic [NB-1:0] data_out;
    logic          controller_clk;
    logic          controller_latch;
    logic [NC-1:0] controller_data_in_B;
    logic          busy;
    logic          fetch_done;

    controller_hub #(
        .NUM_CONTROLLERS(NC),
        .NUM_BUTTONS    (NB),
        .CLK_DIV        (CD)
    ) dut (
        .cpu_clk             (cpu_clk),
        .rst                 (rst),
        .start_fetch         (start_fetch),
        .reg_select          (reg_select),
        .read_strobe         (read_strobe),
        .reg_address         (reg_address),
        .data_out            (data_out),
        .controller_clk      (controller_clk),
        .controller_latch    (controller_latch),
        .controller_data_in_B(controller_data_in_B),
        .busy                (busy),
        .fetch_done          (fetch_done)
    );

    always #5 cpu_clk = ~cpu_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge cpu_clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Controller model: pattern bit = 1 means button down; the first bit
    // presented after the latch is the MSB, advancing on each rising clk.
    logic [NB-1:0] pattern [NC];
    int            bit_pos = 0;

    function automatic logic pin_level(input logic [NB-1:0] p, input int pos);
        logic [NB-1:0] t;
        if (pos >= NB) return 1'b1;
        t = p << pos;
        return ~t[NB-1];
    endfunction

    always @(posedge controller_clk or posedge controller_latch or negedge rst) begin
        if (!rst || controller_latch) bit_pos <= 0;
        else                          bit_pos <= bit_pos + 1;
    end

    always_comb begin
        for (int c = 0; c < NC; c++)
            controller_data_in_B[c] = pin_level(pattern[c], bit_pos);
    end

    // Reference register contents
    logic [NB-1:0] held_m    [NC];
    logic [NB-1:0] pressed_m [NC];

    // Scoreboard queues
    int            done_q[$];
    logic [NB-1:0] read_q[$];

    task automatic model_read(input int idx, input bit sel_p, input bit strobe,
                              output logic [NB-1:0] v);
        v = '0;
        if (idx < NC) begin
            v = sel_p ? pressed_m[idx] : held_m[idx];
            if (sel_p && strobe) pressed_m[idx] = '0;
        end
    endtask

    task automatic drive_read(input int idx, input bit sel_p, input bit strobe);
        logic [NB-1:0] v;
        int            i2;
        i2 = idx;
        model_read(idx, sel_p, strobe, v);
        read_q.push_back(v);
        reg_address = {i2[AW-2:0], sel_p};
        reg_select  = 1'b1;
        read_strobe = strobe;
    endtask

    task automatic rd(input int idx, input bit sel_p, input bit strobe);
        @(posedge cpu_clk); #1;
        drive_read(idx, sel_p, strobe);
        @(posedge cpu_clk); #1;
        reg_select  = 1'b0;
        read_strobe = 1'b0;
    endtask

    task automatic fetch(input bit collide, input int cidx, input bit retrig, input bit mid_read);
        int base;
        int exp_done;
        @(posedge cpu_clk); #1;
        start_fetch = 1'b1;
        base        = cyc;
        exp_done    = base + LAT;
        done_q.push_back(exp_done);
        @(posedge cpu_clk); #1;
        while (cyc < exp_done) begin
            reg_select  = 1'b0;
            read_strobe = 1'b0;
            start_fetch = retrig && (cyc == base + 50);
            if (mid_read && cyc == base + 30)
                drive_read(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)));
            @(posedge cpu_clk); #1;
        end
        start_fetch = 1'b0;
        reg_select  = 1'b0;
        read_strobe = 1'b0;
        // This is the commit cycle: an optional strobed pressed read lands here.
        if (collide) drive_read(cidx, 1'b1, 1'b1);
        for (int c = 0; c < NC; c++) begin
            pressed_m[c] = pressed_m[c] | (pattern[c] & ~held_m[c]);
            held_m[c]    = pattern[c];
        end
        @(posedge cpu_clk); #1;
        reg_select  = 1'b0;
        read_strobe = 1'b0;
    endtask

    task automatic abort_fetch();
        int base;
        @(posedge cpu_clk); #1;
        start_fetch = 1'b1;
        base        = cyc;
        @(posedge cpu_clk); #1;
        start_fetch = 1'b0;
        while (cyc < base + 60) begin
            @(posedge cpu_clk); #1;
        end
        check("abort_busy_mid", busy, 1);
        rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", fetch_done, 0);
        check("abort_clk", controller_clk, 1);
        check("abort_latch", controller_latch, 0);
        for (int c = 0; c < NC; c++) begin
            held_m[c]    = '0;
            pressed_m[c] = '0;
        end
        repeat (3) @(posedge cpu_clk);
        #1 rst = 1'b1;
    endtask

    // Monitor: waveform shape, fetch_done timing and read data.
    int latch_run = 0;
    int low_run = 0;
    int low_pulses = 0;
    int busy_run = 0;

    always @(negedge cpu_clk) begin
        if (!rst) begin
            latch_run  = 0;
            low_run    = 0;
            low_pulses = 0;
            busy_run   = 0;
        end else begin
            if (controller_latch) latch_run++;
            else if (latch_run != 0) begin
                check("latch_len", latch_run, 2 * CD);
                latch_run = 0;
            end
            if (!controller_clk) low_run++;
            else if (low_run != 0) begin
                check("clk_low_len", low_run, CD);
                low_pulses++;
                low_run = 0;
            end
            if (busy) busy_run++;
            if (fetch_done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    check("done_cycle", cyc, done_q.pop_front());
                    check("busy_len", busy_run, LAT);
                    check("clk_pulses", low_pulses, NB);
                end
            end
            if (!busy) begin
                busy_run   = 0;
                low_pulses = 0;
            end
            if (reg_select) begin
                if (read_q.size() == 0) check("unexpected_read", 1, 0);
                else check("read_data", data_out, read_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < NC; c++) begin
            pattern[c]   = '0;
            held_m[c]    = '0;
            pressed_m[c] = '0;
        end
        #3 rst = 1'b0;
        repeat (3) @(posedge cpu_clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", fetch_done, 0);
        check("rst_clk", controller_clk, 1);
        check("rst_latch", controller_latch, 0);
        rst = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd(a, 1'b0, 1'b0);
            rd(a, 1'b1, 1'b0);
        end

        // Basic fetch: controller 0 presses 1010_0001
        pattern[0] = 8'hA1;
        fetch(1'b0, 0, 1'b0, 1'b1);
        for (int a = 0; a < 4; a++) rd(a, 1'b0, 1'b0);
        rd(0, 1'b1, 1'b1);
        rd(0, 1'b1, 1'b1);

        // Edge detect against previous frame
        pattern[0] = 8'hA3;
        fetch(1'b0, 0, 1'b0, 1'b0);
        rd(0, 1'b1, 1'b1);
        rd(0, 1'b0, 1'b0);

        // Collision: pressed=10, new edge 04, strobed read during commit
        pattern[0] = 8'h10;
        fetch(1'b0, 0, 1'b0, 1'b0);
        pattern[0] = 8'h14;
        fetch(1'b1, 0, 1'b0, 1'b0);
        rd(0, 1'b1, 1'b0);

        // Retrigger while busy must be ignored
        pattern[1] = 8'h5A;
        fetch(1'b0, 0, 1'b1, 1'b0);
        repeat (130) @(posedge cpu_clk);
        rd(3, 1'b1, 1'b1);
        rd(3, 1'b0, 1'b0);
        rd(1, 1'b1, 1'b0);

        // Abort mid-fetch, then a clean all-pressed fetch
        pattern[0] = 8'h3C;
        abort_fetch();
        for (int a = 0; a < 4; a++) begin
            rd(a, 1'b0, 1'b0);
            rd(a, 1'b1, 1'b0);
        end
        for (int c = 0; c < NC; c++) pattern[c] = 8'hFF;
        fetch(1'b0, 0, 1'b0, 1'b0);
        for (int a = 0; a < NC; a++) begin
            rd(a, 1'b0, 1'b0);
            rd(a, 1'b1, 1'b0);
        end

        // Randomized frames
        for (int it = 0; it < 20; it++) begin
            for (int c = 0; c < NC; c++) pattern[c] = NB'($urandom);
            fetch(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0, 1'b1);
            repeat ($urandom_range(1, 4))
                rd(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge cpu_clk);
        check("pending_done", done_q.size(), 0);
        check("pending_reads", read_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controller_hub.md
Name: controller_hub

Overview:
- Parametrised next-generation controller interface: serially fetches N shift-register game controllers in parallel and exposes per-controller "held" and sticky "pressed-since-last-read" registers to the CPU.
- Driven entirely from cpu_clk, with an internal divider generating the controller shift clock, so no separate controller clock input is needed.
- Sits beside the address decoder. A fetch is triggered by the GPU's per-frame start-fetch pulse.

Parameters:
- NUM_CONTROLLERS, 4, number of controller channels (1..8).
- NUM_BUTTONS, 8, bits shifted per controller per fetch (1..16).
- CLK_DIV, 6, cpu_clk cycles per half-period of controller_clk (>=1).

Ports:
- cpu_clk  in  1  sole clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start_fetch  in  1  one-cycle fetch request.
- reg_select  in  1  CPU access to this block decoded.
- read_strobe  in  1  qualifies a CPU read this cycle (drives clear-on-read).
- reg_address  in  $clog2(NUM_CONTROLLERS)+1  bit0: 0=held, 1=pressed; upper bits: controller index.
- data_out  out  NUM_BUTTONS  register read data.
- controller_clk  out  1  shift clock to controllers.
- controller_latch  out  1  parallel-load strobe to controllers.
- controller_data_in_B  in  NUM_CONTROLLERS  serial data, active-low (0 = button down).
- busy  out  1  fetch in progress.
- fetch_done  out  1  one-cycle pulse when new values are committed.

Behaviour:
- Reset (rst=0, async):
  - FSM=IDLE; held, pressed, shift regs and divider all 0.
  - controller_clk=1, controller_latch=0, busy=0, fetch_done=0.
- FSM IDLE -> LATCH -> SHIFT -> COMMIT -> IDLE. All control outputs are registered.
- IDLE:
  - controller_clk=1, latch=0.
  - start_fetch=1 at an edge enters LATCH and clears the divider and bit index.
- LATCH:
  - controller_latch=1 for exactly 2*CLK_DIV cycles; controller_clk stays 1.
  - Then enter SHIFT.
- SHIFT: NUM_BUTTONS bit periods of 2*CLK_DIV cycles each.
  - controller_clk=0 for the first CLK_DIV cycles of each period, 1 for the second CLK_DIV.
  - All channels are sampled on the last cycle of the low phase: shift[c] <= {shift[c][NUM_BUTTONS-2:0], ~controller_data_in_B[c]}.
  - The first sampled bit ends in bit NUM_BUTTONS-1.
  - After the last period, enter COMMIT.
- COMMIT, 1 cycle:
  - held[c] <= shift[c]; pressed[c] <= (pressed[c] & ~clr[c]) | (shift[c] & ~held_old[c]).
  - fetch_done=1; next state IDLE.
- busy=1 in LATCH, SHIFT and COMMIT.
- Latency: fetch_done is high exactly (NUM_BUTTONS+1)*2*CLK_DIV+1 cycles after the edge that samples start_fetch. This is 109 with defaults.
- start_fetch while busy: ignored, not queued.
- Reads (combinational):
  - data_out = selected register when reg_select=1 and index < NUM_CONTROLLERS; otherwise 0.
  - Held and pressed values change only in COMMIT; mid-fetch reads return the previous frame's values.
- Clear-on-read:
  - Trigger: reg_select & read_strobe & bit0=1 with a valid index.
  - Effect: clears that controller's pressed register at the edge (clr[c]).
  - If COMMIT coincides, new edges survive the clear; older bits are cleared.
  - Reading held has no side effect. Out-of-range index: no side effect.
- Reset mid-fetch: immediate abort to reset state; partial shift data discarded; no fetch_done.
- Widths:
  - Divider counter is $clog2(2*CLK_DIV) bits, wrapping at 2*CLK_DIV-1.
  - Bit index is $clog2(NUM_BUTTONS+1) bits.

Test Plan:
- Reset then idle: rst low mid-run -> all outputs at reset values, controller_clk=1, data_out=0 for every address.
- Basic fetch (defaults): controller 0 models serial 8'b1010_0001 active-low, others all released; pulse start_fetch.
  - Required: latch high 12 cycles, then 8 clk low/high periods of 6/6.
  - fetch_done at cycle 109; busy high cycles 1..109.
  - held[0]=8'hA1, pressed[0]=8'hA1, held[1..3]=0.
- Edge detect + clear-on-read: second fetch with controller 0 = 8'hA3.
  - Read pressed[0] before the second fetch -> 8'hA1, then 0.
  - After the second fetch: pressed[0]=8'h02, held[0]=8'hA3.
- Collision: pressed read strobe on controller 0 in the same cycle as COMMIT with new edge 8'h04 and pressed=8'h10 -> pressed[0]=8'h04.
- Busy/retrigger: start_fetch pulsed again at cycle 50 -> ignored, single fetch_done at 109. Out-of-range reg_address index (NUM_CONTROLLERS=3, index 3) -> data_out=0.
- Abort: rst asserted at cycle 60 of a fetch, released, new fetch of 8'hFF -> no stale bits; held=8'hFF, fetch_done at 109 after the new start.
